// File: rtl/montgomery_pkg.sv
// Shared types and defaults for the bit-serial Montgomery multiplier.
package montgomery_pkg;

  localparam int DEFAULT_WIDTH = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/mont_iter_step.sv
// One radix-2 Montgomery iteration: C' = (C + a_bit*b [+ m if odd]) / 2.
module mont_iter_step
  import montgomery_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH+1:0] c_in,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] c_out
);

  logic [WIDTH+2:0] sum_ab;
  logic [WIDTH+2:0] sum_m;

  // One guard bit above C so the odd-fixup add can never wrap before the shift.
  always_comb begin
    sum_ab = {1'b0, c_in} + (a_bit ? {3'b000, b} : '0);
    sum_m  = sum_ab[0] ? (sum_ab + {3'b000, m}) : sum_ab;
    c_out  = (WIDTH+2)'(sum_m >> 1);
  end

endmodule

// File: rtl/montgomery_mult_param.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod m, start/done handshake.
module montgomery_mult_param
  import montgomery_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH+1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIDTH+1:0] c_step;
  logic [WIDTH-1:0] c_diff;
  logic             c_ge_m;

  // a_q is shifted right each iteration so the current multiplier bit is always a_q[0].
  mont_iter_step #(.WIDTH(WIDTH)) u_step (
    .c_in  (c_q),
    .a_bit (a_q[0]),
    .b     (b_q),
    .m     (m_q),
    .c_out (c_step)
  );

  // C < 2m here, so only the low WIDTH bits of C - m are ever needed.
  always_comb begin
    c_ge_m = (c_q >= {2'b00, m_q});
    c_diff = c_q[WIDTH-1:0] - m_q;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = in_a;
          b_d   = in_b;
          m_d   = in_m;
          c_d   = '0;
          cnt_d = '0;
          err_d = 1'b0;
          if (in_m[0]) begin
            state_d = LOOP;
          end else begin
            state_d  = FIN;
            result_d = '0;
            err_d    = 1'b1;
          end
        end
      end
      LOOP: begin
        c_d   = c_step;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = SUB;
        end
      end
      SUB: begin
        result_d = c_ge_m ? c_diff : c_q[WIDTH-1:0];
        err_d    = 1'b0;
        state_d  = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign err    = err_q;
  assign done   = (state_q == FIN);
  assign busy   = (state_q != IDLE);

endmodule

// File: doc/montgomery_mult_param.md
Name: montgomery_mult_param

Overview:
- Width-parametrised, bit-serial (radix-2) Montgomery modular multiplier.
- Computes result = a·b·2^(−WIDTH) mod m.
- Successor to the fixed 1024-bit multiplier. Adds:
  - a WIDTH parameter
  - a busy output
  - even-modulus error detection
  - defined start-while-busy behaviour
- Sits under the modular-exponentiation controller, which drives it with a start/done handshake.

Parameters:
- WIDTH, 1024, operand/modulus width in bits; legal range is ≥4.
- CNT_W, $clog2(WIDTH+1), derived localparam; iteration counter width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- in_a  input  WIDTH  multiplicand; contract: in_a < in_m.
- in_b  input  WIDTH  multiplier; contract: in_b < in_m.
- in_m  input  WIDTH  modulus; must be odd.
- result  output  WIDTH  registered Montgomery product; held until the next accepted start.
- done  output  1  one-cycle pulse when result/err are valid.
- busy  output  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
- err  output  1  registered, valid with done; 1 means even modulus.

Behaviour:
- Reset: resetn sampled low at a rising edge clears outputs and state.
  - result=0, done=0, busy=0, err=0; state=IDLE; accumulator and counter cleared.
  - Reset during LOOP/SUB aborts the operation; no done pulse is issued.
- States:
  - IDLE → LOOP on start when in_m[0]=1.
  - IDLE → FIN on start when in_m[0]=0.
  - LOOP → SUB after WIDTH iterations.
  - SUB → FIN.
  - FIN → IDLE.
- Accept edge (IDLE, start=1): latch a, b, m internally; C=0; i=0. Inputs may change freely afterwards.
- LOOP: one iteration per edge, i = 0 … WIDTH−1.
  - C ← C + a[i]·b
  - if C is odd, C ← C + m
  - C ← C >> 1
  - C is WIDTH+2 bits; no overflow is permitted.
  - Leave LOOP when i == WIDTH−1.
- SUB: if C ≥ m then result ← C − m, else result ← C[WIDTH−1:0]. Set err=0.
  - Given a, b < m, C < 2m, so one subtraction suffices.
- FIN: done=1 for exactly one cycle; busy=1 in this cycle. Next edge returns to IDLE with done=0.
- Latency, measured from the accept edge:
  - done is high after WIDTH+2 edges (WIDTH loop edges, 1 SUB edge, 1 FIN edge).
  - WIDTH=1024 → done after 1026 edges.
- Even modulus: skip LOOP/SUB. Set result=0 and err=1. done is high after 1 edge.
- start when not IDLE (including the FIN cycle): ignored, with no side effects on result, done or busy.
- start held high continuously: a new operation is accepted on the first IDLE edge after FIN. Back-to-back throughput is WIDTH+3 edges per operation.
- err is cleared on the next accepted start. result is not cleared until SUB or an even-modulus FIN.
- Operands ≥ m: the result is unspecified, but it must be some WIDTH-bit value and done must still pulse with the same latency.

Decomposition:
- Package montgomery_pkg holds:
  - state enum (IDLE, LOOP, SUB, FIN), 2-bit encoding
  - DEFAULT_WIDTH = 1024
- Sub-module mont_iter_step: combinational single iteration.
  - Inputs: C (WIDTH+2 bits), a_bit, b, m.
  - Output: next C.
  - Exists so a radix-4 variant can later swap the step without touching the FSM.
- The final conditional subtraction stays inline in the top module.

Test Plan:
- WIDTH=8, m=0xC5, a=0x2A, b=0x17, one start pulse → done after exactly 10 edges, result=0xBE, err=0, busy high for 10 cycles.
- WIDTH=8, m=0xC5, a=0x84 (R² mod m), b=0x01 → result=0x3B (R mod m). Also a=0x00, b=0x55 → result=0x00.
- WIDTH=8, m=0xC5, a=b=0xC4 (m−1, exercises final subtraction) → result=0xBB.
- WIDTH=8, m=0xC4 (even) → done after 1 edge, err=1, result=0x00. A following run with m=0xC5, a=0x2A, b=0x17 → err=0, result=0xBE.
- WIDTH=8: assert start again 3 cycles after accept with different operands → ignored; original result 0xBE is returned on schedule. Then resetn low at cycle 5 of a new operation → outputs cleared, no done pulse, next start works normally.
- WIDTH=1024, generator-script random vectors with odd m (≥20 runs, start held high for back-to-back runs) → every result matches the generator; done spacing is 1027 edges.
